// File: rtl/exp_fixed_point.sv
// exp_fixed_point
//   Two-stage pipelined e^x approximator using the third-order Taylor
//   polynomial 1 + x + x^2/2 + x^3/6. Every arithmetic step truncates.
//
//   Operand x_in is read as unsigned Q1.FRAC (FRAC = WIDTH-1), so x is in [0, 2).
//   Result exp_out is Q.FRAC in a double-width signed word and is never negative.
//
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset; clears every register and wins over enable
//   enable  : advances both stages together; all registers hold when low
//   x_in    : operand, WIDTH bits, bit pattern read as unsigned Q1.FRAC
//   exp_out : registered result, 2*WIDTH bits signed, valid two enabled edges after x_in
module exp_fixed_point #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic signed [WIDTH-1:0]   x_in,
    output logic signed [2*WIDTH-1:0] exp_out
);

    localparam int FRAC = WIDTH - 1;
    localparam int X2_W = WIDTH + 1;   // floor(u^2 / 2^FRAC) < 2^(WIDTH+1)
    localparam int X3_W = WIDTH + 2;   // floor(x2 * u / 2^FRAC) < 2^(WIDTH+2)
    localparam int OUT_W = 2 * WIDTH;

    localparam logic [OUT_W-1:0] ONE = OUT_W'(1) << FRAC;
    localparam logic [X3_W-1:0]  SIX = X3_W'(6);

    // Square of the operand, rescaled to Q.FRAC by dropping the low FRAC bits.
    function automatic logic [X2_W-1:0] trunc_square(input logic [WIDTH-1:0] u);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, u} * {{WIDTH{1'b0}}, u};
        return prod[FRAC +: X2_W];
    endfunction

    // Cube from the stored square, again dropping the low FRAC bits.
    function automatic logic [X3_W-1:0] trunc_cube(input logic [X2_W-1:0] x2,
                                                   input logic [WIDTH-1:0] u);
        logic [X2_W+WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, x2} * {{X2_W{1'b0}}, u};
        return prod[FRAC +: X3_W];
    endfunction

    // ONE + u + x2/2 + x3/6, all truncating; the sum always fits OUT_W bits.
    function automatic logic signed [OUT_W-1:0] poly_sum(input logic [X2_W-1:0] x2,
                                                         input logic [WIDTH-1:0] u);
        logic [X3_W-1:0]  x3;
        logic [X3_W-1:0]  t3;
        logic [X2_W-1:0]  t2;
        logic [OUT_W-1:0] acc;
        x3  = trunc_cube(x2, u);
        t3  = x3 / SIX;
        t2  = x2 >> 1;
        acc = ONE
            + {{(OUT_W-WIDTH){1'b0}}, u}
            + {{(OUT_W-X2_W){1'b0}}, t2}
            + {{(OUT_W-X3_W){1'b0}}, t3};
        return $signed(acc);
    endfunction

    logic [WIDTH-1:0] u_p0;
    logic [WIDTH-1:0] u_p1;
    logic [X2_W-1:0]  x2_p1;

    assign u_p0 = $unsigned(x_in);

    // Stage 1: capture operand and its truncated square
    always_ff @(posedge clk) begin
        if (rst) begin
            u_p1  <= '0;
            x2_p1 <= '0;
        end else if (enable) begin
            u_p1  <= u_p0;
            x2_p1 <= trunc_square(u_p0);
        end
    end

    // Stage 2: cube, divide and accumulate into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_out <= '0;
        end else if (enable) begin
            exp_out <= poly_sum(x2_p1, u_p1);
        end
    end

endmodule

// File: tb/tb_exp_fixed_point.sv
module tb_exp_fixed_point;

    localparam int WIDTH = 8;
    localparam int FRAC  = WIDTH - 1;
    localparam int ONE   = 1 << FRAC;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      enable = 1'b0;
    logic signed [WIDTH-1:0]   x_in = '0;
    logic signed [2*WIDTH-1:0] exp_out;

    int errors = 0;
    int checks = 0;

    exp_fixed_point #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .x_in    (x_in),
        .exp_out (exp_out)
    );

    always #5 clk = ~clk;

    // Reference: the truncating Taylor polynomial in plain integer arithmetic.
    function automatic int model_exp(input int x);
        int x2, x3;
        x2 = (x * x) >> FRAC;
        x3 = (x2 * x) >> FRAC;
        return ONE + x + x2 / 2 + x3 / 6;
    endfunction

    // Operands accepted since the last reset; the output always reflects the
    // operand accepted two enabled edges earlier (or zero-state before that).
    int q[$];
    int exp_model = 0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_model = 0;
            model_valid = 1'b1;
        end else if (enable) begin
            q.push_back(int'($unsigned(x_in)));
            if (q.size() >= 2) exp_model = model_exp(q[q.size()-2]);
            else               exp_model = model_exp(0);
            if (q.size() > 2) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (exp_out !== (2*WIDTH)'(exp_model)) begin
                errors++;
                $display("FAIL model_cmp t=%0t exp_out=%0d expected=%0d", $time, exp_out, exp_model);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1; enable = 1'b1; x_in = 8'h55;
        tick(); tick();
        check("reset_zero", int'(exp_out), 0);

        // Hold 1.0
        rst = 1'b0; enable = 1'b1; x_in = 8'h80;
        tick(); check("first_edge_one", int'(exp_out), 128);
        tick(); check("x1p0", int'(exp_out), 341);
        tick(); check("x1p0_stable", int'(exp_out), 341);

        // Back-to-back stream
        x_in = 8'h00; tick(); check("stream_a", int'(exp_out), 341);
        x_in = 8'h40; tick(); check("stream_x0", int'(exp_out), 128);
        x_in = 8'h80; tick(); check("stream_x0p5", int'(exp_out), 210);
        x_in = 8'hFF; tick(); check("stream_x1p0", int'(exp_out), 341);
        x_in = 8'hC0; tick(); check("stream_xff", int'(exp_out), 805);
        tick();               check("x1p5", int'(exp_out), 536);

        // Enable gating
        x_in = 8'h80; tick(); check("pre_hold", int'(exp_out), 536);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x_in = 8'($urandom_range(0, 255));
            tick();
            check("hold_frozen", int'(exp_out), 536);
        end
        enable = 1'b1; x_in = 8'h40;
        tick(); check("resume_old", int'(exp_out), 341);
        tick(); check("resume_new", int'(exp_out), 210);

        // Mid-stream reset
        x_in = 8'hFF; tick();
        rst = 1'b1; tick(); check("midreset_zero", int'(exp_out), 0);
        rst = 1'b0; x_in = 8'h40; tick(); check("postreset_one", int'(exp_out), 128);
        x_in = 8'hC0; tick(); check("postreset_a", int'(exp_out), 210);
        tick(); check("postreset_b", int'(exp_out), 536);

        // Random stream: enable ~75%, occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 3) != 0);
            x_in   = 8'($urandom_range(0, 255));
            tick();
        end
        rst = 1'b0; enable = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_fixed_point.md
# exp_fixed_point

Pipelined fixed-point exponential approximator: computes e^x with a third-order Taylor polynomial, 1 + x + x²/2 + x³/6. It takes an unsigned Q1.(WIDTH-1) operand and produces a Q(WIDTH+1).(WIDTH-1) result in a double-width signed output. The block is a two-stage, enable-gated datapath primitive for math/activation pipelines and has no handshake beyond `enable`.

## Interface
- `WIDTH`, default 8: operand width. `FRAC = WIDTH-1` is a local parameter giving the number of fractional bits on input and output. WIDTH ≥ 4 is required.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `enable`  input  1: advances both pipeline stages when high; everything holds when low.
- `x_in`  input  WIDTH: operand. The port is declared signed, but its bits are interpreted as unsigned Q1.FRAC, so x = x_in[WIDTH-1:0] / 2^FRAC, with range [0, 2).
- `exp_out`  output  2*WIDTH (signed): result in Q.FRAC, so e^x ≈ exp_out / 2^FRAC. It is always non-negative.

## Operation
- Constant `ONE = 1 << FRAC` (128 for WIDTH=8).
- Let `u = x_in` zero-extended, treated as unsigned.
- Stage 1 registers:
  - `u_s1 = u`
  - `x2_s1 = (u*u) >> FRAC`, a truncating shift, width WIDTH+1 bits.
- Stage 2 register `exp_out`, computed from stage-1 values:
  - `x3 = (x2_s1 * u_s1) >> FRAC`, truncating.
  - `t2 = x2_s1 >> 1`.
  - `t3 = x3 / 6`, exact integer division truncated toward zero (operands are non-negative).
  - `exp_out = ONE + u_s1 + t2 + t3`.
- All intermediates are unsigned and sized without overflow. For WIDTH=8 the maximum is x_in=0xFF → 805, which fits in 16 bits.
- No rounding anywhere; every step truncates. The result must match the formula above bit-exactly.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge): `u_s1`, `x2_s1` and `exp_out` all become 0. Reset has priority over `enable`.
- `enable`=1 at a rising edge loads stage 1 from `x_in` and stage 2 from the old stage-1 contents, simultaneously.
- `enable`=0 at a rising edge: all registers hold, and `exp_out` stays stable indefinitely.
- Latency is 2 enabled edges. An `x_in` sampled at enabled edge N appears on `exp_out` after enabled edge N+1.
- Throughput is one new operand per enabled cycle; back-to-back operands stream without bubbles.
- First enabled edge after reset: stage 2 computes from zeroed stage 1, so `exp_out` = ONE (128). The result for the first real operand follows one enabled edge later.
- Reset mid-stream discards all in-flight operands. `exp_out` is 0 after the reset edge.
- `exp_out` is a registered output with no combinational path from `x_in` or `enable`.

## Test plan
- Reset, then `x_in`=0x80 (1.0) with `enable`=1 held → `exp_out`=341 within 2 edges and stable thereafter. The breakdown is 128+128+64+21; e≈348, so it is inside the ±31 tolerance.
- `x_in`=0x00 → 128; `x_in`=0x40 (0.5) → 210 (128+64+16+2); `x_in`=0xC0 (1.5) → 536 (128+192+144+72); `x_in`=0xFF → 805.
- Stream 0x00, 0x40, 0x80, 0xFF on consecutive enabled edges → `exp_out` shows 128, 210, 341, 805 on consecutive edges, each lagging its input by 2 edges.
- Load 0x80, drop `enable` after 1 edge for 5 cycles while changing `x_in` → `exp_out` is frozen at its prior value. Re-enabling yields 341 on the next edge, then the new operand's result.
- Assert `rst` for one edge with `enable`=1 mid-stream → `exp_out`=0 the next cycle, then 128, then the correct results for post-reset operands.
